sccb_slave_regfile: RTL



---
 rtl/sccb_pkg.sv | 26 ++
 rtl/sccb_line_sync.sv | 44 ++++
 rtl/sccb_slave_regfile.sv | 163 ++++++++++++++++
 3 files changed

// File: rtl/sccb_pkg.sv
// Shared SCCB definitions: protocol state encoding, OV2640 identity constants
// and the read-only register test used by both the responder and the master driver.
package sccb_pkg;

  typedef enum logic [3:0] {
    IDLE,
    ID,
    ID_ACK,
    ADDR,
    ADDR_ACK,
    WDATA,
    WDATA_ACK,
    RDATA,
    RDATA_NA,
    IGNORE
  } sccb_state_e;

  localparam logic [7:0] OV2640_ID  = 8'h60;
  localparam logic [7:0] PID_H_ADDR = 8'h0A;
  localparam logic [7:0] PID_L_ADDR = 8'h0B;

  function automatic logic is_read_only(input logic [7:0] addr);
    return (addr == PID_H_ADDR) || (addr == PID_L_ADDR);
  endfunction

endpackage

// File: rtl/sccb_line_sync.sv
// Two-flop synchronizers for SIO_C/SIO_D plus edge, START and STOP detection
// on the synchronized values.
module sccb_line_sync (
  input  logic clk,
  input  logic rst,
  input  logic scl,
  input  logic sda,
  output logic sda_s,
  output logic scl_rise,
  output logic scl_fall,
  output logic start,
  output logic stop
);

  logic scl_m, scl_s, scl_q;
  logic sda_m, sda_q;

  // Idle bus is pulled high, so the synchronizers reset to 1 to avoid a
  // phantom START right after reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      scl_m <= 1'b1;
      scl_s <= 1'b1;
      scl_q <= 1'b1;
      sda_m <= 1'b1;
      sda_s <= 1'b1;
      sda_q <= 1'b1;
    end else begin
      // NOTE: non-blocking assignments let the flop chain shift one stage per clk.
      scl_m <= scl;
      scl_s <= scl_m;
      scl_q <= scl_s;
      sda_m <= sda;
      sda_s <= sda_m;
      sda_q <= sda_s;
    end
  end

  assign scl_rise = scl_s & ~scl_q;
  assign scl_fall = ~scl_s & scl_q;
  assign start    = scl_s & scl_q & sda_q & ~sda_s;
  assign stop     = scl_s & scl_q & ~sda_q & sda_s;

endmodule

// File: rtl/sccb_slave_regfile.sv
// SCCB responder emulating the OV2640 register interface: 3-phase writes,
// 2-phase reads, backed by a 256x8 register file with a host peek port.
module sccb_slave_regfile
  import sccb_pkg::*;
#(
  parameter logic [7:0] SLAVE_ID = OV2640_ID,
  parameter bit         ACK_EN   = 1'b1,
  parameter logic [7:0] PID_H    = 8'h26,
  parameter logic [7:0] PID_L    = 8'h42,
  parameter logic [7:0] REG_RST  = 8'h00
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       sio_c,
  inout  wire        sio_d,
  output logic       wr_stb,
  output logic [7:0] wr_addr,
  output logic [7:0] wr_data,
  input  logic [7:0] peek_addr,
  output logic [7:0] peek_data,
  output logic       busy
);

  logic        sda_s, scl_rise, scl_fall, start, stop;
  sccb_state_e state;
  logic [3:0]  bit_cnt;
  logic [7:0]  shift_in, rd_sh, addr_q;
  logic        rw_q, sda_oe, commit;
  logic [7:0]  regs [256];

  sccb_line_sync u_sync (
    .clk      (clk),
    .rst      (rst),
    .scl      (sio_c),
    .sda      (sio_d),
    .sda_s    (sda_s),
    .scl_rise (scl_rise),
    .scl_fall (scl_fall),
    .start    (start),
    .stop     (stop)
  );

  // Open drain: the block only ever pulls low.
  assign sio_d  = sda_oe ? 1'b0 : 1'bz;
  assign commit = (state == WDATA) && scl_fall && (bit_cnt == 4'd8) && !start && !stop;

  // NOTE: the register file must come out of reset with known contents, so it
  // is built from resettable flops rather than an inferred RAM.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 256; i++) begin
        if (8'(i) == PID_H_ADDR)      regs[i] <= PID_H;
        else if (8'(i) == PID_L_ADDR) regs[i] <= PID_L;
        else                          regs[i] <= REG_RST;
      end
    end else if (commit && !is_read_only(addr_q)) begin
      regs[addr_q] <= shift_in;
    end
  end

  // Registered peek: a same-cycle commit is visible on the following cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) peek_data <= 8'h00;
    else     peek_data <= regs[peek_addr];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      bit_cnt  <= 4'd0;
      shift_in <= 8'h00;
      rd_sh    <= 8'h00;
      addr_q   <= 8'h00;
      rw_q     <= 1'b0;
      sda_oe   <= 1'b0;
      wr_stb   <= 1'b0;
      wr_addr  <= 8'h00;
      wr_data  <= 8'h00;
      busy     <= 1'b0;
    end else begin
      // NOTE: default assignment turns wr_stb into a single-cycle pulse.
      wr_stb <= 1'b0;
      if (start) begin
        state   <= ID;
        bit_cnt <= 4'd0;
        sda_oe  <= 1'b0;
        busy    <= 1'b1;
      end else if (stop) begin
        state   <= IDLE;
        bit_cnt <= 4'd0;
        sda_oe  <= 1'b0;
        busy    <= 1'b0;
      end else begin
        case (state)
          ID, ADDR, WDATA: begin
            if (scl_rise && bit_cnt < 4'd8) begin
              shift_in <= {shift_in[6:0], sda_s};
              bit_cnt  <= bit_cnt + 4'd1;
            end else if (scl_fall && bit_cnt == 4'd8) begin
              bit_cnt <= 4'd0;
              sda_oe  <= ACK_EN;
              if (state == ID) begin
                if (shift_in == SLAVE_ID) begin
                  rw_q  <= 1'b0;
                  state <= ID_ACK;
                end else if (shift_in == (SLAVE_ID | 8'h01)) begin
                  rw_q  <= 1'b1;
                  state <= ID_ACK;
                end else begin
                  sda_oe <= 1'b0;
                  state  <= IGNORE;
                end
              end else if (state == ADDR) begin
                addr_q <= shift_in;
                state  <= ADDR_ACK;
              end else begin
                wr_stb  <= 1'b1;
                wr_addr <= addr_q;
                wr_data <= shift_in;
                state   <= WDATA_ACK;
              end
            end
          end
          ID_ACK: if (scl_fall) begin
            if (rw_q) begin
              rd_sh  <= regs[addr_q];
              sda_oe <= ~regs[addr_q][7];
              state  <= RDATA;
            end else begin
              sda_oe <= 1'b0;
              state  <= ADDR;
            end
          end
          ADDR_ACK: if (scl_fall) begin
            sda_oe <= 1'b0;
            state  <= WDATA;
          end
          WDATA_ACK: if (scl_fall) begin
            sda_oe <= 1'b0;
            state  <= IGNORE;
          end
          RDATA: begin
            if (scl_rise && bit_cnt < 4'd8) begin
              bit_cnt <= bit_cnt + 4'd1;
            end else if (scl_fall) begin
              if (bit_cnt == 4'd8) begin
                bit_cnt <= 4'd0;
                sda_oe  <= 1'b0;
                state   <= RDATA_NA;
              end else begin
                rd_sh  <= {rd_sh[6:0], 1'b0};
                sda_oe <= ~rd_sh[6];
              end
            end
          end
          RDATA_NA: if (scl_fall) state <= IGNORE;
          default: ;
        endcase
      end
    end
  end

endmodule
